// File: rtl/refresh_pkg.sv
// Shared types and helpers for the DDR4 refresh scheduler: command record and
// bank-sequence stepping used by the per-rank controllers.
package refresh_pkg;

   localparam int MAX_RWIDTH   = 4;
   localparam int MAX_BGWIDTH  = 4;
   localparam int MAX_BAWIDTH  = 4;
   localparam int DEF_BGWIDTH  = 2;
   localparam int DEF_BAWIDTH  = 2;
   localparam int DEF_NBANKS   = 2**(DEF_BGWIDTH + DEF_BAWIDTH);

   // Fields are sized for the widest supported geometry; users slice them down.
   typedef struct packed {
      logic [MAX_RWIDTH-1:0]  rank;
      logic [MAX_BGWIDTH-1:0] bg;
      logic [MAX_BAWIDTH-1:0] ba;
      logic                   all;
      logic                   urgent;
   } ref_cmd_t;

   // Bank index is bg*2**baw+ba. Order 0 steps ba fastest, order 1 steps bg fastest.
   function automatic int next_bank(input int idx, input int order, input int bgw, input int baw);
      int bg;
      int ba;
      int nb;
      nb = 1 << (bgw + baw);
      if (order == 0) begin
         return (idx + 1) % nb;
      end
      bg = idx >> baw;
      ba = idx % (1 << baw);
      if (bg == (1 << bgw) - 1) begin
         bg = 0;
         ba = (ba + 1) % (1 << baw);
      end else begin
         bg = bg + 1;
      end
      return (bg << baw) + ba;
   endfunction

endpackage

// File: rtl/refresh_rank_ctrl.sv
// Per-rank refresh bookkeeping: tREFI credit counter, per-bank round bitmap,
// per-bank tRFC lock timers and the next REF candidate for this rank.
module refresh_rank_ctrl
   import refresh_pkg::*;
#(
   parameter int  BGWIDTH     = 2,
   parameter int  BAWIDTH     = 2,
   parameter int  TREFI       = 10400,
   parameter int  TRFC_AB     = 467,
   parameter int  TRFC_PB     = 200,
   parameter int  MAXPOSTPONE = 8,
   parameter int  ORDER       = 1,
   localparam int NBANKS      = 2**(BGWIDTH + BAWIDTH),
   localparam int IDXW        = BGWIDTH + BAWIDTH
) (
   input  logic                   ck_t,
   input  logic                   reset,
   input  logic                   en,
   input  logic                   mode_pb,
   input  logic [NBANKS-1:0]      bank_busy,
   input  logic                   fire,
   input  logic                   fire_all,
   input  logic [MAX_BGWIDTH-1:0] fire_bg,
   input  logic [MAX_BAWIDTH-1:0] fire_ba,
   output logic                   cand_valid,
   output logic                   cand_all,
   output logic                   cand_urgent,
   output logic [IDXW-1:0]        cand_bank,
   output logic [NBANKS-1:0]      refreshing
);

   localparam int CNTW = (TREFI > 1) ? $clog2(TREFI) : 1;
   localparam int CRW  = $clog2(MAXPOSTPONE + 1);
   localparam int TW   = $clog2(((TRFC_AB > TRFC_PB) ? TRFC_AB : TRFC_PB) + 1);

   logic [CNTW-1:0]   refi_cnt_reg;
   logic [CRW-1:0]    credit_reg;
   logic [CRW-1:0]    credit_next;
   logic [NBANKS-1:0] bitmap_reg;
   logic [NBANKS-1:0] bank_hit;
   logic [IDXW-1:0]   last_bank_reg;
   logic [IDXW-1:0]   search_idx;
   logic [IDXW-1:0]   pb_bank;
   logic              round_pb_reg;
   logic              eff_pb;
   logic              urgent;
   logic              tick;
   logic              pb_fire;
   logic              round_done;
   logic              consume;
   logic              all_ok;
   logic              pb_found;
   logic [TW-1:0]     timer_reg [NBANKS];

   assign tick       = en && (refi_cnt_reg == CNTW'(TREFI - 1));
   assign urgent     = (credit_reg == CRW'(MAXPOSTPONE));
   // The mode is only followed between rounds; an open round keeps per-bank mode.
   assign eff_pb     = (bitmap_reg == '0) ? mode_pb : round_pb_reg;
   assign pb_fire    = fire && !fire_all;
   assign round_done = pb_fire && ((bitmap_reg | bank_hit) == '1);
   assign consume    = (fire && fire_all) || round_done;
   assign all_ok     = (refreshing == '0) && (urgent || (bank_busy == '0));

   always_comb begin
      credit_next = credit_reg;
      if (tick && !consume && !urgent) begin
         credit_next = credit_reg + 1'b1;
      end else if (!tick && consume && (credit_reg != '0)) begin
         credit_next = credit_reg - 1'b1;
      end
   end

   // Walk the bank sequence starting after the last issued bank; busy banks are skipped.
   always_comb begin
      pb_found   = 1'b0;
      pb_bank    = '0;
      search_idx = last_bank_reg;
      for (int k = 0; k < NBANKS; k++) begin
         search_idx = IDXW'(next_bank(int'(search_idx), ORDER, BGWIDTH, BAWIDTH));
         if (!pb_found && !bitmap_reg[search_idx] && !refreshing[search_idx] &&
             (urgent || !bank_busy[search_idx])) begin
            pb_found = 1'b1;
            pb_bank  = search_idx;
         end
      end
   end

   assign cand_valid  = (credit_reg != '0) && (eff_pb ? pb_found : all_ok);
   assign cand_all    = !eff_pb;
   assign cand_urgent = urgent;
   assign cand_bank   = eff_pb ? pb_bank : '0;

   always_ff @(posedge ck_t) begin
      if (reset) begin
         refi_cnt_reg  <= '0;
         credit_reg    <= '0;
         bitmap_reg    <= '0;
         last_bank_reg <= IDXW'(NBANKS - 1);
         round_pb_reg  <= 1'b0;
      end else begin
         if (en) begin
            refi_cnt_reg <= tick ? '0 : refi_cnt_reg + 1'b1;
         end
         credit_reg <= credit_next;
         if (bitmap_reg == '0) begin
            round_pb_reg <= mode_pb;
         end
         if (pb_fire) begin
            round_pb_reg  <= 1'b1;
            last_bank_reg <= {fire_bg[BGWIDTH-1:0], fire_ba[BAWIDTH-1:0]};
            bitmap_reg    <= round_done ? '0 : (bitmap_reg | bank_hit);
         end
      end
   end

   for (genvar gi = 0; gi < NBANKS; gi++) begin : g_bank
      assign bank_hit[gi] = fire && (fire_all ||
                            ((fire_bg == MAX_BGWIDTH'(gi / (2**BAWIDTH))) &&
                             (fire_ba == MAX_BAWIDTH'(gi % (2**BAWIDTH)))));

      always_ff @(posedge ck_t) begin
         if (reset) begin
            timer_reg[gi] <= '0;
         end else if (bank_hit[gi]) begin
            timer_reg[gi] <= fire_all ? TW'(TRFC_AB) : TW'(TRFC_PB);
         end else if (timer_reg[gi] != '0) begin
            timer_reg[gi] <= timer_reg[gi] - 1'b1;
         end
      end

      assign refreshing[gi] = (timer_reg[gi] != '0);
   end

endmodule

// File: rtl/refresh_interleave_sched.sv
// DDR4 refresh command generator: per-rank controllers feed a rank arbiter
// (urgent first, then round-robin) and a registered valid/ready command stage.
module refresh_interleave_sched
   import refresh_pkg::*;
#(
   parameter int  RANKS       = 1,
   parameter int  BGWIDTH     = 2,
   parameter int  BAWIDTH     = 2,
   parameter int  TREFI       = 10400,
   parameter int  TRFC_AB     = 467,
   parameter int  TRFC_PB     = 200,
   parameter int  MAXPOSTPONE = 8,
   parameter int  ORDER       = 1,
   localparam int RWIDTH      = (RANKS > 1) ? $clog2(RANKS) : 1,
   localparam int NBANKS      = 2**(BGWIDTH + BAWIDTH),
   localparam int IDXW        = BGWIDTH + BAWIDTH
) (
   input  logic                    ck_t,
   input  logic                    reset,
   input  logic                    en,
   input  logic                    mode_pb,
   input  logic [RANKS*NBANKS-1:0] bank_busy,
   output logic                    ref_valid,
   input  logic                    ref_ready,
   output logic [RWIDTH-1:0]       ref_rank,
   output logic [BGWIDTH-1:0]      ref_bg,
   output logic [BAWIDTH-1:0]      ref_ba,
   output logic                    ref_all,
   output logic                    ref_urgent,
   output logic [RANKS*NBANKS-1:0] bank_refreshing
);

   logic [RANKS-1:0]  cand_valid;
   logic [RANKS-1:0]  cand_all;
   logic [RANKS-1:0]  cand_urgent;
   logic [RANKS-1:0]  rank_fire;
   logic [IDXW-1:0]   cand_bank [RANKS];
   logic              valid_reg;
   logic              fire;
   ref_cmd_t          cmd_reg;
   ref_cmd_t          cmd_next;
   logic [RWIDTH-1:0] last_rank_reg;
   logic [RWIDTH-1:0] rr_idx;
   logic [RWIDTH-1:0] urg_rank;
   logic [RWIDTH-1:0] any_rank;
   logic [RWIDTH-1:0] pick;
   logic              urg_found;
   logic              any_found;

   assign fire = valid_reg && ref_ready;

   for (genvar gi = 0; gi < RANKS; gi++) begin : g_rank
      assign rank_fire[gi] = fire && (cmd_reg.rank == MAX_RWIDTH'(gi));

      refresh_rank_ctrl #(
         .BGWIDTH     (BGWIDTH),
         .BAWIDTH     (BAWIDTH),
         .TREFI       (TREFI),
         .TRFC_AB     (TRFC_AB),
         .TRFC_PB     (TRFC_PB),
         .MAXPOSTPONE (MAXPOSTPONE),
         .ORDER       (ORDER)
      ) u_rank (
         .ck_t        (ck_t),
         .reset       (reset),
         .en          (en),
         .mode_pb     (mode_pb),
         .bank_busy   (bank_busy[gi*NBANKS +: NBANKS]),
         .fire        (rank_fire[gi]),
         .fire_all    (cmd_reg.all),
         .fire_bg     (cmd_reg.bg),
         .fire_ba     (cmd_reg.ba),
         .cand_valid  (cand_valid[gi]),
         .cand_all    (cand_all[gi]),
         .cand_urgent (cand_urgent[gi]),
         .cand_bank   (cand_bank[gi]),
         .refreshing  (bank_refreshing[gi*NBANKS +: NBANKS])
      );
   end

   // Both searches start at the rank after the last one that fired.
   always_comb begin
      urg_found = 1'b0;
      any_found = 1'b0;
      urg_rank  = '0;
      any_rank  = '0;
      rr_idx    = '0;
      for (int k = 1; k <= RANKS; k++) begin
         rr_idx = RWIDTH'((int'(last_rank_reg) + k) % RANKS);
         if (!urg_found && cand_valid[rr_idx] && cand_urgent[rr_idx]) begin
            urg_found = 1'b1;
            urg_rank  = rr_idx;
         end
         if (!any_found && cand_valid[rr_idx]) begin
            any_found = 1'b1;
            any_rank  = rr_idx;
         end
      end
      pick = urg_found ? urg_rank : any_rank;
   end

   always_comb begin
      cmd_next        = '0;
      cmd_next.rank   = MAX_RWIDTH'(pick);
      cmd_next.bg     = MAX_BGWIDTH'(cand_bank[pick][IDXW-1:BAWIDTH]);
      cmd_next.ba     = MAX_BAWIDTH'(cand_bank[pick][BAWIDTH-1:0]);
      cmd_next.all    = cand_all[pick];
      cmd_next.urgent = cand_urgent[pick];
   end

   // The offer is frozen until accepted; a new candidate is taken only while idle.
   always_ff @(posedge ck_t) begin
      if (reset) begin
         valid_reg     <= 1'b0;
         cmd_reg       <= '0;
         last_rank_reg <= RWIDTH'(RANKS - 1);
      end else if (valid_reg) begin
         if (ref_ready) begin
            valid_reg     <= 1'b0;
            last_rank_reg <= cmd_reg.rank[RWIDTH-1:0];
         end
      end else if (any_found) begin
         valid_reg <= 1'b1;
         cmd_reg   <= cmd_next;
      end
   end

   assign ref_valid  = valid_reg;
   assign ref_rank   = cmd_reg.rank[RWIDTH-1:0];
   assign ref_bg     = cmd_reg.bg[BGWIDTH-1:0];
   assign ref_ba     = cmd_reg.ba[BAWIDTH-1:0];
   assign ref_all    = cmd_reg.all;
   assign ref_urgent = cmd_reg.urgent;

endmodule

// File: tb/tb_refresh_interleave_sched.sv
// Directed bench for refresh_interleave_sched: two ranks, short tREFI/tRFC,
// hand-computed offer cycles, bank order and lock windows.
module tb_refresh_interleave_sched;

   logic        ck_t = 1'b0;
   logic        reset = 1'b1;
   logic        en = 1'b0;
   logic        mode_pb = 1'b0;
   logic        ref_ready = 1'b0;
   logic [31:0] bank_busy = '0;
   logic        ref_valid;
   logic [0:0]  ref_rank;
   logic [1:0]  ref_bg;
   logic [1:0]  ref_ba;
   logic        ref_all;
   logic        ref_urgent;
   logic [31:0] bank_refreshing;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   always #5 ck_t = ~ck_t;

   refresh_interleave_sched #(
      .RANKS       (2),
      .BGWIDTH     (2),
      .BAWIDTH     (2),
      .TREFI       (64),
      .TRFC_AB     (20),
      .TRFC_PB     (8),
      .MAXPOSTPONE (4),
      .ORDER       (1)
   ) dut (
      .ck_t            (ck_t),
      .reset           (reset),
      .en              (en),
      .mode_pb         (mode_pb),
      .bank_busy       (bank_busy),
      .ref_valid       (ref_valid),
      .ref_ready       (ref_ready),
      .ref_rank        (ref_rank),
      .ref_bg          (ref_bg),
      .ref_ba          (ref_ba),
      .ref_all         (ref_all),
      .ref_urgent      (ref_urgent),
      .bank_refreshing (bank_refreshing)
   );

   task automatic tick();
      @(negedge ck_t);
      cyc++;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (3) @(negedge ck_t);
      reset = 1'b0;
      cyc = 0;
   endtask

   task automatic wait_valid(input int limit, input string name);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (!ref_valid && n < limit);
      tests++;
      if (!ref_valid) begin
         fails++;
         $display("FAIL %s: ref_valid=0 after %0d cycles, required an offer", name, n);
      end
   endtask

   task automatic test_reset();
      en = 1'b1; mode_pb = 1'b0; ref_ready = 1'b1; bank_busy = '0;
      do_reset();
      tests++;
      if ({ref_valid, ref_rank, ref_bg, ref_ba, ref_all, ref_urgent} !== 8'h00) begin
         fails++;
         $display("FAIL reset_outputs: got %b, required 00000000",
                  {ref_valid, ref_rank, ref_bg, ref_ba, ref_all, ref_urgent});
      end
      tests++;
      if (bank_refreshing !== 32'h0) begin
         fails++;
         $display("FAIL reset_refreshing: got %h, required 00000000", bank_refreshing);
      end
      $display("[TB] reset: outputs %b refreshing %h", {ref_valid, ref_all, ref_urgent}, bank_refreshing);
   endtask

   task automatic test_all_bank();
      int cnt;
      en = 1'b1; mode_pb = 1'b0; ref_ready = 1'b1; bank_busy = '0;
      do_reset();
      wait_valid(200, "ab_first");
      $display("[TB] all_bank offer cyc %0d rank %0d all %0b", cyc, ref_rank, ref_all);
      tests++;
      if (cyc !== 65) begin
         fails++;
         $display("FAIL ab_first_cycle: got %0d, required 65", cyc);
      end
      tests++;
      if ({ref_rank, ref_all, ref_urgent, ref_bg, ref_ba} !== 7'b0100000) begin
         fails++;
         $display("FAIL ab_first_fields: got rank=%0d all=%0b urg=%0b bg=%0d ba=%0d, required rank=0 all=1 urg=0 bg=0 ba=0",
                  ref_rank, ref_all, ref_urgent, ref_bg, ref_ba);
      end
      tick();
      tests++;
      if (ref_valid !== 1'b0 || bank_refreshing !== 32'h0000_FFFF) begin
         fails++;
         $display("FAIL ab_after_fire: got valid=%0b refreshing=%h, required valid=0 refreshing=0000ffff",
                  ref_valid, bank_refreshing);
      end
      cnt = 1;
      for (int n = 0; n < 40; n++) begin
         tick();
         if (cyc == 67) begin
            $display("[TB] all_bank offer cyc %0d rank %0d all %0b", cyc, ref_rank, ref_all);
            tests++;
            if ({ref_valid, ref_rank, ref_all} !== 3'b111) begin
               fails++;
               $display("FAIL ab_rank1_offer: got valid=%0b rank=%0d all=%0b, required valid=1 rank=1 all=1",
                        ref_valid, ref_rank, ref_all);
            end
         end
         if (cyc == 68) begin
            tests++;
            if (bank_refreshing[31:16] !== 16'hFFFF) begin
               fails++;
               $display("FAIL ab_rank1_lock: got %h, required ffff", bank_refreshing[31:16]);
            end
         end
         if (bank_refreshing[15:0] == 16'hFFFF) cnt++;
         else break;
      end
      tests++;
      if (cnt !== 20) begin
         fails++;
         $display("FAIL ab_lock_len: got %0d cycles, required 20", cnt);
      end
   endtask

   task automatic test_per_bank();
      logic [1:0] ebg, eba;
      en = 1'b1; mode_pb = 1'b1; ref_ready = 1'b1; bank_busy = 32'hFFFF_0000;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         ebg = 2'(i % 4);
         eba = 2'(i / 4);
         wait_valid(100, "pb_offer");
         $display("[TB] per_bank offer %0d cyc %0d bg %0d ba %0d", i, cyc, ref_bg, ref_ba);
         tests++;
         if (cyc !== 65 + 2 * i || {ref_rank, ref_all, ebg, eba} !== {1'b0, 1'b0, ref_bg, ref_ba}) begin
            fails++;
            $display("FAIL pb_order[%0d]: got cyc=%0d rank=%0d all=%0b bg=%0d ba=%0d, required cyc=%0d rank=0 all=0 bg=%0d ba=%0d",
                     i, cyc, ref_rank, ref_all, ref_bg, ref_ba, 65 + 2 * i, ebg, eba);
         end
         if (i == 0) begin
            tick();
            tests++;
            if (ref_valid !== 1'b0 || bank_refreshing !== 32'h0000_0001) begin
               fails++;
               $display("FAIL pb_lock: got valid=%0b refreshing=%h, required valid=0 refreshing=00000001",
                        ref_valid, bank_refreshing);
            end
         end
      end
      wait_valid(100, "pb_next_round");
      $display("[TB] per_bank offer 16 cyc %0d bg %0d ba %0d", cyc, ref_bg, ref_ba);
      tests++;
      if (cyc !== 129 || {ref_all, ref_bg, ref_ba} !== 5'b00000) begin
         fails++;
         $display("FAIL pb_credit_spent: got cyc=%0d all=%0b bg=%0d ba=%0d, required cyc=129 all=0 bg=0 ba=0",
                  cyc, ref_all, ref_bg, ref_ba);
      end
   endtask

   task automatic test_busy_skip();
      int p;
      logic [1:0] ebg, eba;
      en = 1'b1; mode_pb = 1'b1; ref_ready = 1'b1; bank_busy = 32'hFFFF_0010;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         p = (i == 0) ? 0 : ((i == 15) ? 1 : i + 1);
         ebg = 2'(p % 4);
         eba = 2'(p / 4);
         wait_valid(100, "skip_offer");
         $display("[TB] busy_skip offer %0d cyc %0d bg %0d ba %0d", i, cyc, ref_bg, ref_ba);
         tests++;
         if ({ref_rank, ref_all, ref_bg, ref_ba} !== {1'b0, 1'b0, ebg, eba}) begin
            fails++;
            $display("FAIL skip_order[%0d]: got rank=%0d all=%0b bg=%0d ba=%0d, required rank=0 all=0 bg=%0d ba=%0d",
                     i, ref_rank, ref_all, ref_bg, ref_ba, ebg, eba);
         end
         if (i == 14) bank_busy = 32'hFFFF_0000;
      end
      wait_valid(100, "skip_next_round");
      $display("[TB] busy_skip offer 16 cyc %0d bg %0d ba %0d", cyc, ref_bg, ref_ba);
      tests++;
      if (cyc !== 129 || {ref_bg, ref_ba} !== 4'b1000) begin
         fails++;
         $display("FAIL skip_next_round: got cyc=%0d bg=%0d ba=%0d, required cyc=129 bg=2 ba=0",
                  cyc, ref_bg, ref_ba);
      end
   endtask

   task automatic test_urgent();
      logic [6:0] snap;
      int diffs;
      en = 1'b1; mode_pb = 1'b0; ref_ready = 1'b0; bank_busy = 32'hFFFF_FFFF;
      do_reset();
      wait_valid(400, "urg_first");
      $display("[TB] urgent offer cyc %0d rank %0d all %0b urgent %0b", cyc, ref_rank, ref_all, ref_urgent);
      tests++;
      if (cyc !== 257 || {ref_rank, ref_all, ref_urgent, ref_bg, ref_ba} !== 7'b0110000) begin
         fails++;
         $display("FAIL urg_first: got cyc=%0d rank=%0d all=%0b urg=%0b bg=%0d ba=%0d, required cyc=257 rank=0 all=1 urg=1 bg=0 ba=0",
                  cyc, ref_rank, ref_all, ref_urgent, ref_bg, ref_ba);
      end
      snap = {ref_rank, ref_all, ref_urgent, ref_bg, ref_ba};
      diffs = 0;
      while (cyc < 300) begin
         tick();
         if (!ref_valid || {ref_rank, ref_all, ref_urgent, ref_bg, ref_ba} !== snap) diffs++;
      end
      tests++;
      if (diffs !== 0) begin
         fails++;
         $display("FAIL urg_hold_stable: got %0d changed cycles, required 0", diffs);
      end
      ref_ready = 1'b1;
      tick();
      tests++;
      if (ref_valid !== 1'b0 || bank_refreshing !== 32'h0000_FFFF) begin
         fails++;
         $display("FAIL urg_fire: got valid=%0b refreshing=%h, required valid=0 refreshing=0000ffff",
                  ref_valid, bank_refreshing);
      end
      tick();
      $display("[TB] urgent offer cyc %0d rank %0d all %0b urgent %0b", cyc, ref_rank, ref_all, ref_urgent);
      tests++;
      if ({ref_valid, ref_rank, ref_all, ref_urgent} !== 4'b1111) begin
         fails++;
         $display("FAIL urg_rank1: got valid=%0b rank=%0d all=%0b urg=%0b, required valid=1 rank=1 all=1 urg=1",
                  ref_valid, ref_rank, ref_all, ref_urgent);
      end
   endtask

   task automatic test_mode_switch();
      logic [1:0] ebg, eba;
      en = 1'b1; mode_pb = 1'b1; ref_ready = 1'b1; bank_busy = 32'hFFFF_0000;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         ebg = 2'(i % 4);
         eba = 2'(i / 4);
         wait_valid(100, "mode_offer");
         $display("[TB] mode_switch offer %0d cyc %0d all %0b bg %0d ba %0d", i, cyc, ref_all, ref_bg, ref_ba);
         tests++;
         if ({ref_rank, ref_all, ref_bg, ref_ba} !== {1'b0, 1'b0, ebg, eba}) begin
            fails++;
            $display("FAIL mode_pb_round[%0d]: got rank=%0d all=%0b bg=%0d ba=%0d, required rank=0 all=0 bg=%0d ba=%0d",
                     i, ref_rank, ref_all, ref_bg, ref_ba, ebg, eba);
         end
         if (i == 4) begin
            tick();
            mode_pb = 1'b0;
         end
      end
      wait_valid(100, "mode_all_bank");
      $display("[TB] mode_switch offer 16 cyc %0d all %0b", cyc, ref_all);
      tests++;
      if (cyc !== 129 || {ref_rank, ref_all, ref_bg, ref_ba} !== 6'b010000) begin
         fails++;
         $display("FAIL mode_all_bank: got cyc=%0d rank=%0d all=%0b bg=%0d ba=%0d, required cyc=129 rank=0 all=1 bg=0 ba=0",
                  cyc, ref_rank, ref_all, ref_bg, ref_ba);
      end
   endtask

   task automatic test_reset_midhs();
      en = 1'b1; mode_pb = 1'b0; ref_ready = 1'b0; bank_busy = '0;
      do_reset();
      wait_valid(200, "rst_offer");
      reset = 1'b1;
      tick();
      $display("[TB] reset_midhs: valid %0b refreshing %h", ref_valid, bank_refreshing);
      tests++;
      if ({ref_valid, ref_rank, ref_bg, ref_ba, ref_all, ref_urgent} !== 8'h00 || bank_refreshing !== 32'h0) begin
         fails++;
         $display("FAIL rst_midhs_clear: got outs=%b refreshing=%h, required outs=00000000 refreshing=00000000",
                  {ref_valid, ref_rank, ref_bg, ref_ba, ref_all, ref_urgent}, bank_refreshing);
      end
      reset = 1'b0;
      cyc = 0;
      ref_ready = 1'b1;
      wait_valid(200, "rst_reoffer");
      $display("[TB] reset_midhs offer cyc %0d rank %0d", cyc, ref_rank);
      tests++;
      if (cyc !== 65 || ref_rank !== 1'b0) begin
         fails++;
         $display("FAIL rst_reoffer: got cyc=%0d rank=%0d, required cyc=65 rank=0", cyc, ref_rank);
      end
   endtask

   initial begin
      test_reset();
      test_all_bank();
      test_per_bank();
      test_busy_skip();
      test_urgent();
      test_mode_switch();
      test_reset_midhs();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
